// File: rtl/irq_latch8_pkg.sv
// irq_latch8_pkg: shared types and constants for the irq_latch8 interrupt front end.
package irq_latch8_pkg;

    localparam int NUM_LINES = 8;
    localparam int ID_W      = 3;

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } state_t;

    localparam logic [NUM_LINES-1:0] RST_MASK = 8'h00;
    localparam logic [NUM_LINES-1:0] RST_PEND = 8'h00;
    localparam logic [NUM_LINES-1:0] RST_OVF  = 8'h00;
    localparam logic [ID_W-1:0]      RST_ID   = 3'd0;

endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational highest-bit-first 8-to-3 encoder with a valid flag.
module prio_enc8
    import irq_latch8_pkg::*;
(
    input  logic [NUM_LINES-1:0] vec,
    output logic [ID_W-1:0]      idx,
    output logic                 valid
);

    always_comb begin
        idx = vec[7] ? 3'd7 :
              vec[6] ? 3'd6 :
              vec[5] ? 3'd5 :
              vec[4] ? 3'd4 :
              vec[3] ? 3'd3 :
              vec[2] ? 3'd2 :
              vec[1] ? 3'd1 : 3'd0;
        valid = |vec;
    end

endmodule

// File: rtl/irq_latch8.sv
// irq_latch8: synchronises eight request lines into sticky pending bits and presents
// one masked, priority-encoded grant held until acknowledged.
module irq_latch8
    import irq_latch8_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LINES-1:0] req_in,
    input  logic                 mask_wr,
    input  logic [NUM_LINES-1:0] mask_wdata,
    output logic [NUM_LINES-1:0] mask,
    output logic [NUM_LINES-1:0] pend,
    output logic [NUM_LINES-1:0] ovf,
    input  logic                 ovf_clr,
    output logic                 irq,
    output logic [ID_W-1:0]      id,
    input  logic                 ack
);

    logic [SYNC_STAGES-1:0] sync_q [NUM_LINES];
    logic [NUM_LINES-1:0]   sync_last, sync_prev;
    logic [NUM_LINES-1:0]   set_v, clr_v, ovf_set, elig;
    logic [ID_W-1:0]        enc_idx, id_d;
    logic                   enc_valid;
    state_t                 state, state_d;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_sync
        always_ff @(posedge clk or posedge rst)
            if (rst) sync_q[i] <= '0;
            else     sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req_in[i]};
        assign sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end

    // A set coinciding with the ack-clear of the same bit keeps it pending without overflow.
    always_comb begin
        set_v   = EDGE_MODE ? (sync_last & ~sync_prev) : sync_last;
        clr_v   = {{(NUM_LINES-1){1'b0}}, state == ST_PRESENT && ack} << id;
        ovf_set = set_v & pend & ~clr_v & {NUM_LINES{EDGE_MODE}};
        elig    = pend & mask;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync_prev <= '0;
            mask      <= RST_MASK;
            pend      <= RST_PEND;
            ovf       <= RST_OVF;
            state     <= ST_IDLE;
            id        <= RST_ID;
        end else begin
            sync_prev <= sync_last;
            mask      <= mask_wr ? mask_wdata : mask;
            pend      <= (pend & ~clr_v) | set_v;
            ovf       <= (ovf_clr ? '0 : ovf) | ovf_set;
            state     <= state_d;
            id        <= id_d;
        end

    prio_enc8 u_enc (
        .vec   (elig),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d = state;
        id_d    = id;
        if (state == ST_IDLE && enc_valid) begin
            state_d = ST_PRESENT;
            id_d    = enc_idx;
        end else if (state == ST_PRESENT && ack) begin
            state_d = ST_IDLE;
        end
    end

    assign irq = state == ST_PRESENT;

endmodule

// File: tb/tb_irq_latch8.sv
// tb_irq_latch8: directed self-checking bench for irq_latch8 (SYNC_STAGES=2, EDGE_MODE=1).
module tb_irq_latch8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = '0;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_wdata = '0;
    logic [7:0] mask, pend, ovf;
    logic       ovf_clr = 1'b0;
    logic       irq;
    logic [2:0] id;
    logic       ack = 1'b0;
    int         errors = 0;
    int         checks = 0;

    irq_latch8 #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .mask_wr(mask_wr), .mask_wdata(mask_wdata),
        .mask(mask), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr), .irq(irq), .id(id), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic test_reset;
        bit seen;
        step(2);
        checks++; if (mask !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", mask); end
        checks++; if (pend !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h want 00", pend); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h want 00", ovf); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", id); end
        rst = 1'b0;
        mask_wdata = 8'hFF;
        mask_wr = 1'b1;
        step(1);
        mask_wr = 1'b0;
        checks++; if (mask !== 8'hFF) begin errors++; $display("FAIL mask_write: got %h want ff", mask); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (irq !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_quiet: irq rose with no requests, got %b want 0", seen); end
    endtask

    task automatic test_single;
        req_in = 8'h20;
        step(3);
        req_in = 8'h00;
        checks++; if (pend !== 8'h20) begin errors++; $display("FAIL single_pend: got %h want 20", pend); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_early: got %b want 0", irq); end
        step(1);
        checks++; if (irq !== 1'b1 || id !== 3'd5) begin errors++; $display("FAIL single_grant: got irq=%b id=%0d want irq=1 id=5", irq, id); end
        do_ack();
        checks++; if (irq !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL single_ack: got irq=%b pend=%h want irq=0 pend=00", irq, pend); end
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_after: got %b want 0", irq); end
    endtask

    task automatic test_priority;
        req_in = 8'h42;
        step(4);
        checks++; if (irq !== 1'b1 || id !== 3'd6) begin errors++; $display("FAIL prio_grant: got irq=%b id=%0d want irq=1 id=6", irq, id); end
        req_in = 8'h80;
        step(3);
        req_in = 8'h00;
        checks++; if (irq !== 1'b1 || id !== 3'd6) begin errors++; $display("FAIL prio_hold: got irq=%b id=%0d want irq=1 id=6", irq, id); end
        checks++; if (pend !== 8'hC2) begin errors++; $display("FAIL prio_pend: got %h want c2", pend); end
        do_ack();
        checks++; if (irq !== 1'b0 || pend !== 8'h82) begin errors++; $display("FAIL prio_gap1: got irq=%b pend=%h want irq=0 pend=82", irq, pend); end
        step(1);
        checks++; if (irq !== 1'b1 || id !== 3'd7) begin errors++; $display("FAIL prio_next7: got irq=%b id=%0d want irq=1 id=7", irq, id); end
        do_ack();
        checks++; if (irq !== 1'b0 || pend !== 8'h02) begin errors++; $display("FAIL prio_gap2: got irq=%b pend=%h want irq=0 pend=02", irq, pend); end
        step(1);
        checks++; if (irq !== 1'b1 || id !== 3'd1) begin errors++; $display("FAIL prio_next1: got irq=%b id=%0d want irq=1 id=1", irq, id); end
        do_ack();
        checks++; if (irq !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL prio_done: got irq=%b pend=%h want irq=0 pend=00", irq, pend); end
    endtask

    task automatic test_mask;
        mask_wdata = 8'h0F;
        mask_wr = 1'b1;
        req_in = 8'h84;
        step(1);
        mask_wr = 1'b0;
        step(2);
        req_in = 8'h00;
        step(1);
        checks++; if (irq !== 1'b1 || id !== 3'd2) begin errors++; $display("FAIL mask_grant: got irq=%b id=%0d want irq=1 id=2", irq, id); end
        checks++; if (pend !== 8'h84) begin errors++; $display("FAIL mask_pend_before: got %h want 84", pend); end
        do_ack();
        checks++; if (pend !== 8'h80) begin errors++; $display("FAIL mask_pend_after: got %h want 80", pend); end
        step(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b want 0", irq); end
        mask_wdata = 8'hFF;
        mask_wr = 1'b1;
        step(1);
        mask_wr = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_new_early: got %b want 0", irq); end
        step(1);
        checks++; if (irq !== 1'b1 || id !== 3'd7) begin errors++; $display("FAIL mask_new_grant: got irq=%b id=%0d want irq=1 id=7", irq, id); end
        do_ack();
        step(1);
    endtask

    task automatic test_ovf;
        req_in = 8'h08;
        step(1);
        req_in = 8'h00;
        step(3);
        checks++; if (irq !== 1'b1 || id !== 3'd3) begin errors++; $display("FAIL ovf_first: got irq=%b id=%0d want irq=1 id=3", irq, id); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL ovf_none: got %h want 00", ovf); end
        req_in = 8'h08;
        step(1);
        req_in = 8'h00;
        step(3);
        checks++; if (ovf !== 8'h08) begin errors++; $display("FAIL ovf_set: got %h want 08", ovf); end
        checks++; if (pend !== 8'h08 || id !== 3'd3) begin errors++; $display("FAIL ovf_pend: got pend=%h id=%0d want pend=08 id=3", pend, id); end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL ovf_clr: got %h want 00", ovf); end
        req_in = 8'h08;
        step(1);
        req_in = 8'h00;
        step(1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++; if (pend !== 8'h08 || irq !== 1'b0) begin errors++; $display("FAIL set_wins: got pend=%h irq=%b want pend=08 irq=0", pend, irq); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL set_wins_ovf: got %h want 00", ovf); end
        step(1);
        checks++; if (irq !== 1'b1 || id !== 3'd3) begin errors++; $display("FAIL set_wins_regrant: got irq=%b id=%0d want irq=1 id=3", irq, id); end
        do_ack();
        checks++; if (pend !== 8'h00) begin errors++; $display("FAIL ovf_final_pend: got %h want 00", pend); end
    endtask

    task automatic test_reset_mid;
        req_in = 8'h10;
        step(1);
        req_in = 8'h00;
        step(3);
        checks++; if (irq !== 1'b1 || id !== 3'd4) begin errors++; $display("FAIL mid_grant: got irq=%b id=%0d want irq=1 id=4", irq, id); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (irq !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL mid_reset: got irq=%b pend=%h want irq=0 pend=00", irq, pend); end
        checks++; if (mask !== 8'h00 || id !== 3'd0) begin errors++; $display("FAIL mid_reset_regs: got mask=%h id=%0d want mask=00 id=0", mask, id); end
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_ovf();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_latch8.md
# irq_latch8

Eight-line interrupt request front end that sits directly upstream of the 8-to-3 priority encoder stage. It synchronises the asynchronous request lines and edge-detects (or level-samples) them into sticky pending bits. It masks the pending bits and presents one granted request index with a valid/acknowledge handshake. The granted index is held stable until software or the downstream consumer acknowledges it.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages per request line; legal range 2..4.
- EDGE_MODE, 1: 1 = set pending on a rising edge of the synchronised line; 0 = set pending while the synchronised line is high.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  8  asynchronous request lines; bit 7 has the highest priority.
- mask_wr  input  1  one-cycle write strobe for the enable mask.
- mask_wdata  input  8  new enable mask (1 = enabled).
- mask  output  8  current enable mask.
- pend  output  8  raw pending bits, before masking.
- ovf  output  8  sticky overflow: an edge arrived on a line that was already pending.
- ovf_clr  input  1  one-cycle strobe that clears all ovf bits.
- irq  output  1  a granted request is presented.
- id  output  3  index of the granted request; valid only while irq = 1.
- ack  input  1  one-cycle acknowledge of the presented id.

## Operation
- Synchroniser: each req_in bit passes through SYNC_STAGES flops, reset to 0. A previous-value flop on the last stage feeds the edge detector.
  - Because the chain resets to 0, a line that is held high through reset release produces exactly one edge in EDGE_MODE 1.
- Set rule: pend[i] is set on a detected edge (EDGE_MODE 1) or on a synchronised high level (EDGE_MODE 0).
  - In EDGE_MODE 1, if pend[i] is already 1 when an edge arrives, ovf[i] is also set.
- Clear rule: pend[id] is cleared at the edge where ack = 1 and irq = 1.
  - Set wins: a set and a clear on the same bit in the same cycle leave pend = 1 and do not set ovf.
- Mask: pend is never altered by masking. Only the mask-enabled bits (pend & mask) are eligible for grant.
- State machine, two states:
  - IDLE → PRESENT when (pend & mask) ≠ 0. At that edge, id is captured as the highest eligible index and irq = 1.
  - PRESENT holds id and irq stable while ack = 0. Changes to mask, new requests and higher-priority arrivals do not change id.
  - PRESENT → IDLE on ack. irq drops at the same edge.
- A mask write during PRESENT does not revoke the grant. A new grant after an ack is evaluated against the mask value current at that time.
- ack in IDLE is ignored: no pending bits change.
- ovf_clr clears all ovf bits. If an overflow event occurs in the same cycle as ovf_clr, that ovf bit ends up set.
- Width rules: id is the 3-bit binary index. When no bit is eligible, the grant logic produces 0, but irq stays 0.

## Timing
- Reset values: mask = 8'h00, pend = 8'h00, ovf = 8'h00, irq = 0, id = 3'd0, state IDLE, all synchroniser and edge flops 0.
- Latency, with req_in first sampled high at edge k and the line enabled in mask:
  - pend[i] = 1 after edge k+SYNC_STAGES.
  - irq = 1 after edge k+SYNC_STAGES+1, if idle at that time.
- Handshake:
  - irq falls at the ack edge and stays low for at least one full cycle.
  - If requests remain eligible, the next grant (irq = 1) appears after the following edge. Back-to-back grants therefore have a minimum 2-cycle period.
- mask_wr takes effect after its edge; the grant logic uses the new mask from the next cycle.
- Reset asserted mid-handshake: irq drops immediately (asynchronously) and all pending requests are lost.

## Structure
- Package irq_latch8_pkg holds:
  - the state enum (ST_IDLE, ST_PRESENT);
  - the constants NUM_LINES = 8 and ID_W = 3;
  - the reset-value constants.
- Sub-module prio_enc8: purely combinational highest-bit-first encoder taking the 8-bit eligible vector and producing a 3-bit index plus an any-valid flag. It is instantiated once, for the grant.
- The synchroniser is a generate loop in the top level, not a separate module.

## Test plan
- Reset check: with reset applied, all outputs are 0. Release reset with req_in = 8'h00 and mask = 8'hFF (write it after reset) → irq stays 0 for 20 cycles.
- Single request: mask = 8'hFF, pulse req_in[5] for 3 cycles → pend = 8'h20 after 2 cycles, then irq = 1 with id = 5. Ack → pend = 8'h00 and irq = 0.
- Priority and hold:
  - req_in bits 1 and 6 rise together → id = 6.
  - Then raise bit 7 while presented → id stays 6 until ack.
  - Next grants are id = 7, then id = 1, each after a 1-cycle irq-low gap.
- Masking: mask = 8'h0F, req_in[7] and req_in[2] pulse → id = 2. pend = 8'h84 before the ack and 8'h80 after it. Writing mask = 8'hFF then grants id = 7.
- Overflow and set-wins:
  - Pulse req_in[3] twice with no ack → ovf = 8'h08. ovf_clr → ovf = 8'h00.
  - Time a req_in[3] edge to reach pend on the ack edge → pend[3] stays 1 and irq reasserts with id = 3.
- Reset mid-operation: with irq = 1 and id = 4, assert rst between clock edges → irq and pend go to 0 immediately, before the next clock edge.
